rr_arbiter_8: RTL

- Sequential round-robin arbiter sharing one resource among 8 requesters.
- Uses the team's 8-to-3 priority-encoding scheme (lowest index wins) applied to a rotated request vector.
- Sits in front of any single shared datapath unit. Issues a registered one-hot grant plus a 3-bit encoded grant index.
- Holds the grant until the owner releases.

---
 rtl/rr_arb_pkg.sv | 39 +++
 rtl/rr_arbiter_8_pick.sv | 21 ++
 rtl/rr_arbiter_8.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
//   N_REQ  : number of requesters (8)
//   ID_W   : width of an encoded requester index (3)
//   state_t: arbiter FSM states
//   pick() : rotating lowest-index-first priority pick
package rr_arb_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Scan vec starting at index 'start', wrapping mod N_REQ; the first set bit wins.
   // The vector is rotated so 'start' lands at bit 0, priority-encoded lowest-first,
   // then the offset is rotated back by adding 'start' (3-bit wrap).
   // The result is meaningless when vec is zero.
   function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] vec,
                                            input logic [ID_W-1:0]  start);
      logic [2*N_REQ-1:0] dbl;
      logic [N_REQ-1:0]   rot;
      logic [ID_W-1:0]    off;
      dbl = {vec, vec};
      rot = dbl[start +: N_REQ];
      off = 3'd0;
      // Walk downward so the lowest set index is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = ID_W'(i);
         end else begin
            off = off;
         end
      end
      return start + off;
   endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Combinational rotating priority picker.
//   vec   [7:0] : candidate request vector
//   start [2:0] : index that has highest priority this pick
//   id    [2:0] : winning index (valid only when any=1)
//   any         : at least one candidate present
module rr_arbiter_8_pick
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] vec,
   input  logic [ID_W-1:0]  start,
   output logic [ID_W-1:0]  id,
   output logic             any
);

   // Rotate, encode and rotate back in one step.
   always_comb begin
      id  = pick(vec, start);
      any = |vec;
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// A grant is held until the owner releases it (release_grant=1 or its request drops);
// the next winner is searched starting just past the previous owner, so the holder
// never wins twice in a row while someone else is waiting.
//
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   req   [7:0]   : request vector, bit i = requester i wants the resource
//   release_grant : owner finished (the name 'release' is a reserved word);
//                   only looked at while grant_valid=1
//   grant [7:0]   : registered one-hot grant, zero when idle
//   grant_id[2:0] : registered index of the owner, zero when idle
//   grant_valid   : registered, high while a grant is asserted
//   timeout       : one-cycle pulse in the cycle a hold limit forces a release
//
// Optional feature: define RR_ARB_TIMEOUT_EN to enable the hold limit of MAX_HOLD
// cycles per grant. Without it the grant is held indefinitely and timeout is 0.
module rr_arbiter_8
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             release_grant,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_valid,
   output logic             timeout
);

   if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_bad_max_hold
      $error("rr_arbiter_8: MAX_HOLD must be in 2..256");
   end

   state_t           state_r, state_n_s;
   logic [ID_W-1:0]  ptr_r, ptr_n_s;
   logic [N_REQ-1:0] grant_r, grant_n_s;
   logic [ID_W-1:0]  grant_id_r, grant_id_n_s;
   logic             grant_valid_r, grant_valid_n_s;

   logic [N_REQ-1:0] pick_vec_s;
   logic [ID_W-1:0]  pick_start_s;
   logic [ID_W-1:0]  pick_id_s;
   logic             pick_any_s;

   logic [ID_W-1:0]  next_owner_s;
   logic             user_rel_s;
   logic             force_rel_s;
   logic             rel_event_s;
   logic             new_grant_s;

   rr_arbiter_8_pick u_pick (
      .vec   (pick_vec_s),
      .start (pick_start_s),
      .id    (pick_id_s),
      .any   (pick_any_s)
   );

   // Index just past the owner; wraps 7 -> 0 naturally in 3 bits.
   assign next_owner_s = grant_id_r + 3'd1;
   // A withdrawn request counts as a release even without release_grant.
   assign user_rel_s   = release_grant | ~req[grant_id_r];

`ifdef RR_ARB_TIMEOUT_EN
   logic [7:0] hold_cnt_r;

   assign force_rel_s = (state_r == GRANT) && !user_rel_s
                        && (hold_cnt_r == 8'(MAX_HOLD - 1));

   // Hold counter: restarts on every new grant, counts while a grant is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_r <= 8'd0;
      end else if (new_grant_s) begin
         hold_cnt_r <= 8'd0;
      end else if (state_n_s == GRANT) begin
         hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
         hold_cnt_r <= 8'd0;
      end
   end
`else
   assign force_rel_s = 1'b0;
`endif

   assign rel_event_s = user_rel_s | force_rel_s;
   assign timeout     = force_rel_s;

   // Next-state, pointer and grant computation.
   always_comb begin
      state_n_s       = state_r;
      ptr_n_s         = ptr_r;
      grant_n_s       = grant_r;
      grant_id_n_s    = grant_id_r;
      grant_valid_n_s = grant_valid_r;
      pick_vec_s      = req;
      pick_start_s    = ptr_r;
      new_grant_s     = 1'b0;
      case (state_r)
         IDLE: begin
            pick_vec_s   = req;
            pick_start_s = ptr_r;
            if (pick_any_s) begin
               state_n_s       = GRANT;
               grant_n_s       = 8'b0000_0001 << pick_id_s;
               grant_id_n_s    = pick_id_s;
               grant_valid_n_s = 1'b1;
               new_grant_s     = 1'b1;
            end else begin
               state_n_s       = IDLE;
               grant_n_s       = 8'b0000_0000;
               grant_id_n_s    = 3'd0;
               grant_valid_n_s = 1'b0;
            end
         end
         GRANT: begin
            // Owner is masked off so any other waiter wins back-to-back.
            pick_vec_s   = req & ~grant_r;
            pick_start_s = next_owner_s;
            if (rel_event_s) begin
               ptr_n_s = next_owner_s;
               if (pick_any_s) begin
                  state_n_s       = GRANT;
                  grant_n_s       = 8'b0000_0001 << pick_id_s;
                  grant_id_n_s    = pick_id_s;
                  grant_valid_n_s = 1'b1;
                  new_grant_s     = 1'b1;
               end else begin
                  state_n_s       = IDLE;
                  grant_n_s       = 8'b0000_0000;
                  grant_id_n_s    = 3'd0;
                  grant_valid_n_s = 1'b0;
               end
            end else begin
               state_n_s = GRANT;
            end
         end
         default: begin
            state_n_s       = IDLE;
            ptr_n_s         = 3'd0;
            grant_n_s       = 8'b0000_0000;
            grant_id_n_s    = 3'd0;
            grant_valid_n_s = 1'b0;
         end
      endcase
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         ptr_r         <= 3'd0;
         grant_r       <= 8'b0000_0000;
         grant_id_r    <= 3'd0;
         grant_valid_r <= 1'b0;
      end else begin
         state_r       <= state_n_s;
         ptr_r         <= ptr_n_s;
         grant_r       <= grant_n_s;
         grant_id_r    <= grant_id_n_s;
         grant_valid_r <= grant_valid_n_s;
      end
   end

   assign grant       = grant_r;
   assign grant_id    = grant_id_r;
   assign grant_valid = grant_valid_r;

endmodule
